// File: rtl/list_reader.sv
// Triangle list store/replayer: writes captured in Idle, replayed on draw_start; tri_valid 2 cycles after draw_start.
// One triangle per 2 cycles; tri_out held stable in Present until tri_ready, writes outside Idle are dropped.
module list_reader #(
    parameter int WI = 8,
    parameter int WF = 8,
    parameter int AW = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          list_w,
    input  logic [2:0][2:0][WI+WF-1:0]    orig_triangle_in,
    input  logic                          load_done,
    input  logic                          clear,
    input  logic                          draw_start,
    input  logic                          tri_ready,
    output logic                          tri_valid,
    output logic [2:0][2:0][WI+WF-1:0]    tri_out,
    output logic                          draw_done,
    output logic                          busy,
    output logic                          list_loaded,
    output logic [AW:0]                   tri_count,
    output logic                          overflow
);
    localparam int W     = WI + WF;
    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]              state_q, state_d;
    logic [AW:0]             count_q, count_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic                    overflow_q, overflow_d;
    logic                    loaded_q, loaded_d;
    logic                    wr_en;
    logic [2:0][2:0][W-1:0]  tri_out_q;
    logic [2:0][2:0][W-1:0]  mem_q [DEPTH];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        loaded_d   = loaded_q;
        wr_en      = 1'b0;

        // clear beats a same-cycle write, and the discarded write is not an overflow
        if (state_q == ST_IDLE && clear) begin
            count_d    = '0;
            loaded_d   = 1'b0;
            overflow_d = 1'b0;
        end else if (list_w) begin
            if (state_q == ST_IDLE && count_q != CNT_FULL) begin
                wr_en   = 1'b1;
                count_d = count_q + CNT_ONE;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (load_done) begin
            loaded_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // post-write count so a write landing with draw_start is replayed
                if (draw_start && loaded_q) begin
                    if (count_d != '0) begin
                        rd_ptr_d = '0;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (tri_ready) begin
                    if ({1'b0, rd_ptr_q} == count_q - CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        state_d  = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            loaded_q   <= 1'b0;
            tri_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            loaded_q   <= loaded_d;
            if (state_q == ST_FETCH) begin
                tri_out_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage carries no reset; a cleared count makes old entries unreachable.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[count_q[AW-1:0]] <= orig_triangle_in;
        end
    end

    assign tri_valid   = (state_q == ST_PRESENT);
    assign draw_done   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign tri_out     = tri_out_q;
    assign list_loaded = loaded_q;
    assign tri_count   = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_list_reader.sv
// Directed bench for list_reader: load/replay, backpressure, overflow, gating, simultaneous events, reset.
module tb_list_reader;
    typedef logic [2:0][2:0][15:0] tri_t;
    typedef logic [2:0][15:0]      vtx_t;

    logic       Clk = 1'b0;
    logic       Reset, list_w, load_done, clear, draw_start, tri_ready;
    tri_t       orig_triangle_in, tri_out;
    logic       tri_valid, draw_done, busy, list_loaded, overflow;
    logic [4:0] tri_count;

    int n_checks = 0;
    int n_fail   = 0;

    tri_t cube [12];
    tri_t pat  [17];

    list_reader #(.WI(8), .WF(8), .AW(4)) dut (
        .Clk(Clk), .Reset(Reset), .list_w(list_w), .orig_triangle_in(orig_triangle_in),
        .load_done(load_done), .clear(clear), .draw_start(draw_start), .tri_ready(tri_ready),
        .tri_valid(tri_valid), .tri_out(tri_out), .draw_done(draw_done), .busy(busy),
        .list_loaded(list_loaded), .tri_count(tri_count), .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    function automatic vtx_t pt(input int i);
        logic [15:0] o;
        o = 16'h0100;
        case (i)
            1: pt = {16'h0, 16'h0, 16'h0};
            2: pt = {16'h0, o, 16'h0};
            3: pt = {o, o, 16'h0};
            4: pt = {o, 16'h0, 16'h0};
            5: pt = {o, 16'h0, o};
            6: pt = {o, o, o};
            7: pt = {16'h0, o, o};
            default: pt = {16'h0, 16'h0, o};
        endcase
    endfunction

    function automatic tri_t mk(input int a, input int b, input int c);
        mk = {pt(a), pt(b), pt(c)};
    endfunction

    function automatic tri_t mkpat(input int k);
        tri_t t;
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 3; c++)
                t[v][c] = {8'(k + 1), 4'(v), 4'(c)};
        mkpat = t;
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Free-running pass with tri_ready=1; checks order, spacing and draw_done cycle.
    task automatic run_pass(input string tag, input int n, input int use_pat);
        int cyc, idx, done_cyc;
        tri_t e;
        tri_ready  = 1'b1;
        draw_start = 1'b1;
        tick;
        draw_start = 1'b0;
        cyc = 1; idx = 0; done_cyc = -1;
        while (cyc < 80 && done_cyc < 0) begin
            if (tri_valid) begin
                e = (use_pat != 0) ? pat[idx % 17] : cube[idx % 12];
                chk({tag, "_tri"}, tri_out, e);
                chk({tag, "_cyc"}, cyc, 2 * idx + 2);
                idx++;
            end
            if (draw_done) done_cyc = cyc;
            else begin
                tick;
                cyc++;
            end
        end
        chk({tag, "_done_cyc"}, done_cyc, 2 * n + 1);
        chk({tag, "_n_tri"}, idx, n);
        tick;
        chk({tag, "_idle"}, {busy, draw_done}, 2'b00);
    endtask

    initial begin
        cube[0]  = mk(1, 2, 3); cube[1]  = mk(1, 3, 4); cube[2]  = mk(4, 3, 6);
        cube[3]  = mk(4, 6, 5); cube[4]  = mk(5, 6, 7); cube[5]  = mk(5, 7, 8);
        cube[6]  = mk(8, 7, 2); cube[7]  = mk(8, 2, 1); cube[8]  = mk(2, 7, 6);
        cube[9]  = mk(2, 6, 3); cube[10] = mk(8, 1, 4); cube[11] = mk(6, 7, 8);
        for (int k = 0; k < 17; k++) pat[k] = mkpat(k);

        Reset = 1'b1; list_w = 1'b0; load_done = 1'b0; clear = 1'b0;
        draw_start = 1'b0; tri_ready = 1'b0; orig_triangle_in = '0;
        tick; tick;
        Reset = 1'b0;
        chk("rst_count", tri_count, 5'd0);
        chk("rst_flags", {tri_valid, draw_done, busy, list_loaded, overflow}, 5'b0);
        chk("rst_tri_out", tri_out, '0);

        // draw_start before load_done is ignored
        draw_start = 1'b1;
        tick;
        draw_start = 1'b0;
        chk("gate_busy", busy, 1'b0);
        tick;
        chk("gate_busy2", {busy, draw_done}, 2'b00);

        for (int k = 0; k < 12; k++) begin
            list_w = 1'b1; orig_triangle_in = cube[k];
            tick;
        end
        list_w = 1'b0;
        chk("load_count", tri_count, 5'd12);
        chk("load_flags", {overflow, list_loaded}, 2'b00);
        load_done = 1'b1;
        tick;
        load_done = 1'b0;
        chk("loaded", list_loaded, 1'b1);

        run_pass("pass1", 12, 0);

        // Second pass with a 5-cycle stall on T3
        tri_ready = 1'b1; draw_start = 1'b1;
        tick;
        draw_start = 1'b0;
        chk("bp_fetch", {busy, tri_valid}, 2'b10);
        for (int k = 0; k < 12; k++) begin
            tick;
            chk("bp_valid", tri_valid, 1'b1);
            chk("bp_tri", tri_out, cube[k]);
            if (k == 3) begin
                tri_ready = 1'b0;
                repeat (5) begin
                    tick;
                    chk("bp_hold_valid", tri_valid, 1'b1);
                    chk("bp_hold_tri", tri_out, cube[3]);
                end
                tri_ready = 1'b1;
            end
            tick;
            if (k < 11) chk("bp_gap", tri_valid, 1'b0);
            else        chk("bp_done", {draw_done, tri_valid}, 2'b10);
        end
        tick;
        chk("bp_idle", busy, 1'b0);

        // Overflow on the 17th write
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clr", {tri_count, list_loaded, overflow}, 7'd0);
        for (int k = 0; k < 17; k++) begin
            list_w = 1'b1; orig_triangle_in = pat[k];
            tick;
            if (k == 15) chk("ovf_not_yet", overflow, 1'b0);
        end
        list_w = 1'b0;
        chk("ovf_count", tri_count, 5'd16);
        chk("ovf_flag", overflow, 1'b1);
        load_done = 1'b1;
        tick;
        load_done = 1'b0;
        run_pass("ovf_pass", 16, 1);

        // Write during Present is dropped and flagged
        clear = 1'b1;
        tick;
        clear = 1'b0;
        list_w = 1'b1; orig_triangle_in = pat[5];
        tick;
        list_w = 1'b0; load_done = 1'b1;
        tick;
        load_done = 1'b0;
        chk("pw_setup", {tri_count, overflow, list_loaded}, {5'd1, 1'b0, 1'b1});
        tri_ready = 1'b0; draw_start = 1'b1;
        tick;
        draw_start = 1'b0;
        tick;
        list_w = 1'b1; orig_triangle_in = pat[9];
        tick;
        list_w = 1'b0;
        chk("pw_ovf", overflow, 1'b1);
        chk("pw_count", tri_count, 5'd1);
        chk("pw_tri", {tri_valid, tri_out}, {1'b1, pat[5]});
        tri_ready = 1'b1;
        tick;
        chk("pw_done", draw_done, 1'b1);
        tick;

        // Empty list pass
        clear = 1'b1;
        tick;
        clear = 1'b0;
        load_done = 1'b1;
        tick;
        load_done = 1'b0;
        chk("empty_setup", {tri_count, list_loaded, overflow}, {5'd0, 1'b1, 1'b0});
        draw_start = 1'b1;
        tick;
        draw_start = 1'b0;
        chk("empty_done", {draw_done, tri_valid, busy}, 3'b101);
        tick;
        chk("empty_idle", {draw_done, tri_valid, busy}, 3'b000);

        // Write and draw_start together with count 0
        list_w = 1'b1; draw_start = 1'b1; orig_triangle_in = pat[7];
        tick;
        list_w = 1'b0; draw_start = 1'b0;
        chk("sim_fetch", {tri_count, busy, tri_valid}, {5'd1, 1'b1, 1'b0});
        tick;
        chk("sim_tri", {tri_valid, tri_out}, {1'b1, pat[7]});
        tick;
        chk("sim_done", draw_done, 1'b1);
        tick;

        // clear beats a same-cycle write
        clear = 1'b1; list_w = 1'b1; orig_triangle_in = pat[2];
        tick;
        clear = 1'b0; list_w = 1'b0;
        chk("clrw", {tri_count, overflow}, 6'd0);

        // Reset during Present
        list_w = 1'b1; orig_triangle_in = pat[1];
        tick;
        list_w = 1'b0; load_done = 1'b1;
        tick;
        load_done = 1'b0; tri_ready = 1'b0; draw_start = 1'b1;
        tick;
        draw_start = 1'b0;
        tick;
        chk("mid_present", {tri_valid, tri_out}, {1'b1, pat[1]});
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        chk("mid_rst", {tri_valid, busy, list_loaded, overflow, draw_done}, 5'b0);
        chk("mid_rst_count", tri_count, 5'd0);
        draw_start = 1'b1;
        tick;
        draw_start = 1'b0;
        chk("mid_ignored", busy, 1'b0);
        tick;
        chk("mid_ignored2", {busy, draw_done}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/list_reader.md
# list_reader

Triangle list store and reader: the consumer end of the object-load path. Captures triangles strobed in by the object loader (`list_w` plus `orig_triangle_in`, three vertices of three WI.WF fixed-point coordinates) into an internal list. On `draw_start`, it replays the list in write order to the transform/raster stage over a valid/ready handshake, then pulses `draw_done`.

## Interface
- `WI`, default 8: integer bits per coordinate.
- `WF`, default 8: fraction bits per coordinate.
- `AW`, default 4: list address width.
  - Capacity `DEPTH = 2**AW` triangles (16 by default).
- `Clk` input, 1 bit: single clock; all state changes on its rising edge.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `list_w` input, 1 bit: write strobe; `orig_triangle_in` is valid in the same cycle.
- `orig_triangle_in` input, [2:0][2:0][WI+WF-1:0]: triangle to store.
  - Vertex-major, {V0,V1,V2}; each vertex {x,y,z}.
- `load_done` input, 1 bit: loader finished; level or pulse.
- `clear` input, 1 bit: empty the list.
- `draw_start` input, 1 bit: begin one replay pass.
- `tri_ready` input, 1 bit: downstream accepts `tri_out` this cycle.
- `tri_valid` output, 1 bit: `tri_out` holds a triangle.
- `tri_out` output, [2:0][2:0][WI+WF-1:0]: triangle being presented.
- `draw_done` output, 1 bit: one-cycle pulse at end of a pass.
- `busy` output, 1 bit: high in any state other than Idle.
- `list_loaded` output, 1 bit: sticky flag; set by `load_done`.
- `tri_count` output, AW+1 bits: number of stored triangles, 0..DEPTH.
- `overflow` output, 1 bit: sticky flag; a write was dropped.

## Operation
- **Reset values:** state Idle; `tri_count`=0, `tri_valid`=0, `tri_out`=0, `draw_done`=0, `busy`=0, `list_loaded`=0, `overflow`=0, read pointer=0.
  - Storage contents are don't-care after reset.
- **Write, Idle state only:**
  - `list_w`=1 and `tri_count`<DEPTH: store at index `tri_count`; `tri_count`+1 next cycle.
  - `list_w`=1 and `tri_count`=DEPTH: drop the write, set `overflow`.
  - `list_w`=1 in any non-Idle state: drop the write, set `overflow`, leave `tri_count` unchanged.
- **`load_done`**=1: sets `list_loaded` next cycle, in any state.
- **`clear`**=1 in Idle: `tri_count`, `list_loaded`, `overflow` all go to 0.
  - Ignored outside Idle.
  - `clear` and `list_w` in the same cycle: `clear` wins; the write is discarded without flagging `overflow`.
- **State machine:**
  - Idle:
    - `draw_start`=1 and `list_loaded`=1 and count≠0: read pointer←0, go to Fetch. Count is the post-write value, so a same-cycle accepted write counts.
    - `draw_start`=1 and `list_loaded`=1 and count=0: go to Done.
    - `draw_start` with `list_loaded`=0: ignored.
  - Fetch: read storage at the read pointer; data registered into `tri_out`; go to Present.
  - Present: `tri_valid`=1 and `tri_out` held stable until `tri_ready`=1.
    - On accept, if pointer = `tri_count`-1: go to Done.
    - On accept otherwise: pointer+1, go to Fetch.
  - Done: `draw_done`=1 for exactly this cycle; go to Idle.
- `draw_start` outside Idle is ignored; there is no queuing.
- The list is preserved after a pass, so repeated `draw_start` replays identical data.

## Timing
- `tri_valid` rises 2 cycles after the `draw_start` cycle.
  - Cycle 0: `draw_start` sampled in Idle.
  - Cycle 1: Fetch.
  - Cycle 2: Present.
- `tri_valid` is a registered state decode: high only in Present, low in the cycle after an accept.
- Throughput: one triangle per 2 cycles with `tri_ready` held high.
  - Full pass of N triangles: `draw_done` high at cycle 2N+1 after `draw_start`.
- Empty list: `draw_done` at cycle 1, with no `tri_valid`.
- `tri_ready` while `tri_valid`=0 has no effect.
- `tri_out` changes only on the Fetch→Present edge; it keeps its last value in Idle and Done.
- Flags `overflow` and `list_loaded` update one cycle after the causing input.
- Reset mid-pass: the next cycle is Idle with all reset values; the stored list is lost (count=0).

## Test plan
- **Load and replay:**
  - Stimulus: 12 consecutive `list_w` pulses (cube faces: T0={P1,P2,P3} … T11={P6,P7,P8}, P5=x 1.0), then `load_done`, then `draw_start` with `tri_ready`=1.
  - Required: `tri_count`=12; `tri_out` sequence T0..T11 in order; `draw_done` at cycle 25.
- **Backpressure:**
  - Stimulus: `tri_ready`=0 for 5 cycles while T3 is presented.
  - Required: `tri_valid` stays 1, `tri_out` stays T3; on accept the next triangle appears 2 cycles later.
- **Overflow:**
  - Stimulus: 17 writes with AW=4; separately, one write during Present.
  - Required: `tri_count`=16, `overflow`=1; entries 0..15 unchanged.
- **Gating and empty list:**
  - Stimulus: `draw_start` before `load_done`, then `load_done`+`clear`+`draw_start` sequence with count 0.
  - Required: first `draw_start` ignored (`busy`=0); empty pass gives `draw_done` at cycle 1 and no `tri_valid`.
- **Simultaneous events:**
  - Stimulus: `list_w`+`draw_start` in the same Idle cycle with count 0 and `list_loaded`=1.
  - Required: one triangle is replayed.
  - Stimulus: `clear`+`list_w` in the same cycle.
  - Required: count 0, `overflow`=0.
- **Reset mid-pass:**
  - Stimulus: assert `Reset` while in Present.
  - Required: next cycle `tri_valid`=0, `tri_count`=0, `busy`=0, `list_loaded`=0; a following `draw_start` is ignored.
